// File: rtl/bcd2bin_pkg.sv
// Shared sizing, FSM encoding and digit limit for the sequential BCD-to-binary converter.
package bcd2bin_pkg;
  localparam int DIGITS        = 4;
  localparam int BIN_W         = 14;
  localparam int CNT_W         = 4;
  localparam int BCD_MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/bcd2bin_seq_digit_adj.sv
// One BCD digit correction for reverse double-dabble: subtract 3 when the shifted digit is 8 or more.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);
  assign adj = (digit >= 4'd8) ? digit - 4'd3 : digit;
endmodule

// File: rtl/bcd2bin_seq.sv
// Packed-BCD to binary converter, one right shift plus per-digit correction per clock.
// Valid input: done 15 clocks after the accepting edge; any digit above 9 short-cuts to DONE in 1 clock.
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = bcd2bin_pkg::DIGITS,
  parameter int BIN_W  = bcd2bin_pkg::BIN_W,
  parameter int CNT_W  = bcd2bin_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin,
  output logic                err
);
  localparam int BW = 4 * DIGITS;
  localparam int WW = BW + BIN_W;

  state_t            state, state_nx;
  logic [BW-1:0]     bcd_sr;
  logic [BIN_W-1:0]  bin_sr;
  logic [CNT_W-1:0]  cnt;
  logic [WW-1:0]     wk_sh;
  logic [BW-1:0]     bcd_adj;
  logic              bcd_bad;

  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'(BCD_MAX_DIGIT)) bcd_bad = 1'b1;
    end
  end

  // Zero enters the MSB; the digit corrections apply to the already-shifted BCD field.
  assign wk_sh = {bcd_sr, bin_sr} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (wk_sh[BIN_W + 4*g +: 4]),
      .adj   (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = bcd_bad ? DONE : SHIFT;
      SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bcd_sr <= '0;
      bin_sr <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      bin    <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (bcd_bad) begin
              err <= 1'b1;
              bin <= '0;
            end else begin
              bcd_sr <= bcd;
              bin_sr <= '0;
              cnt    <= '0;
              err    <= 1'b0;
            end
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_adj;
          bin_sr <= wk_sh[BIN_W-1:0];
          cnt    <= cnt + CNT_W'(1);
        end
        DONE: begin
          busy <= 1'b0;
          // The error path cleared bin at acceptance and never loaded the shift register.
          if (!err) bin <= bin_sr;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Table-driven and hand-sequenced checks of bcd2bin_seq with a queue scoreboard on done.
module tb_bcd2bin_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic [13:0] bin;
  logic        err;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int prev_bin = 0;

  typedef struct {
    int bin;
    bit err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] bcd;
    logic [15:0] chg;
    int          exp_bin;
    bit          exp_err;
    int          pulse_at;
  } vec_t;
  vec_t vecs[12];

  bcd2bin_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_done: actual done with bin=%0d, required no done", bin);
      end else begin
        e = sb.pop_front();
        chk("sb_bin", int'(bin), e.bin);
        chk("sb_err", int'(err), int'(e.err));
        if (!e.err) chk("bcd_sr_zero", int'(dut.bcd_sr), 0);
      end
    end
  end

  task automatic push_exp(input int b, input bit e);
    exp_t x;
    x.bin = b;
    x.err = e;
    sb.push_back(x);
    exp_done++;
  endtask

  task automatic conv(input logic [15:0] v, input logic [15:0] chg, input int exp_bin,
                      input bit exp_err, input int pulse_at);
    int lat;
    bit busy_ok;
    bit hold_ok;
    @(negedge clk);
    bcd   = v;
    start = 1'b1;
    push_exp(exp_bin, exp_err);
    @(negedge clk);
    start   = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (!exp_err && int'(bin) != prev_bin) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
      if (lat == 2) bcd = chg;
      start = (pulse_at >= 0 && lat == pulse_at);
    end
    start = 1'b0;
    chk($sformatf("latency_%h", v), lat, exp_err ? 1 : 15);
    chk($sformatf("busy_during_%h", v), int'(busy_ok), 1);
    chk($sformatf("bin_held_%h", v), int'(hold_ok), 1);
    chk($sformatf("busy_at_done_%h", v), int'(busy), 0);
    @(negedge clk);
    chk($sformatf("done_width_%h", v), int'(done), 0);
    prev_bin = exp_err ? 0 : exp_bin;
  endtask

  initial begin
    int lat;
    int d1;
    int d2;
    int dc;

    vecs[0]  = '{16'h0000, 16'h0000, 0,    1'b0, -1};
    vecs[1]  = '{16'h9999, 16'h9999, 9999, 1'b0, -1};
    vecs[2]  = '{16'h1234, 16'h5678, 1234, 1'b0, -1};
    vecs[3]  = '{16'h12A4, 16'h12A4, 0,    1'b1, -1};
    vecs[4]  = '{16'h0042, 16'h0042, 42,   1'b0, -1};
    vecs[5]  = '{16'h0500, 16'h0500, 500,  1'b0, 5};
    vecs[6]  = '{16'h0001, 16'h0001, 1,    1'b0, -1};
    vecs[7]  = '{16'h8888, 16'h8888, 8888, 1'b0, -1};
    vecs[8]  = '{16'h0F00, 16'h0F00, 0,    1'b1, -1};
    vecs[9]  = '{16'h9000, 16'h9000, 9000, 1'b0, -1};
    vecs[10] = '{16'h0090, 16'h0090, 90,   1'b0, -1};
    vecs[11] = '{16'h00A0, 16'h00A0, 0,    1'b1, -1};

    rst_n = 1'b0;
    start = 1'b0;
    bcd   = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin",  int'(bin),  0);
    chk("rst_err",  int'(err),  0);
    rst_n = 1'b1;

    foreach (vecs[i])
      conv(vecs[i].bcd, vecs[i].chg, vecs[i].exp_bin, vecs[i].exp_err, vecs[i].pulse_at);

    // Start held high: second acceptance on the first IDLE cycle after DONE.
    @(negedge clk);
    bcd   = 16'h0321;
    start = 1'b1;
    push_exp(321, 1'b0);
    push_exp(321, 1'b0);
    lat = 0;
    d1  = -1;
    d2  = -1;
    while (d2 < 0 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) begin
        if (d1 < 0) d1 = lat;
        else d2 = lat;
      end
      if (lat == 17) start = 1'b0;
    end
    start = 1'b0;
    chk("held_first_done", d1, 16);
    chk("held_second_done", d2, 32);
    prev_bin = 321;
    repeat (20) @(negedge clk);

    // Reset in the middle of a conversion aborts it without a done pulse.
    @(negedge clk);
    bcd   = 16'h8888;
    start = 1'b1;
    push_exp(8888, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_bin",  int'(bin),  0);
    chk("abort_err",  int'(err),  0);
    void'(sb.pop_back());
    exp_done--;
    dc = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);
    prev_bin = 0;
    conv(16'h0001, 16'h0001, 1, 1'b0, -1);

    repeat (5) @(negedge clk);
    chk("total_done_pulses", done_cnt, exp_done);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
